// File: rtl/flags_status_unit_pkg.sv
// rtl/flags_status_unit_pkg.sv - shared flag/branch types and the branch condition evaluator
package flags_status_unit_pkg;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_NN     = 3'd6,
        COND_NEVER  = 3'd7
    } branch_cond_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef logic [2:0] flags_t;

    function automatic logic cond_met(input branch_cond_t cond, input flags_t flags);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_Z:      met = flags[FLAG_Z];
            COND_NZ:     met = ~flags[FLAG_Z];
            COND_C:      met = flags[FLAG_C];
            COND_NC:     met = ~flags[FLAG_C];
            COND_N:      met = flags[FLAG_N];
            COND_NN:     met = ~flags[FLAG_N];
            COND_NEVER:  met = 1'b0;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/flags_status_unit_if.sv
// rtl/flags_status_unit_if.sv - control-unit/ALU side bundle of the flags status unit
interface flags_status_unit_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  alu_carry_i;
    logic                  load_flags_i;
    logic                  load_zn_i;
    logic                  set_carry_i;
    logic                  clr_carry_i;
    logic                  push_i;
    logic                  pop_i;
    logic                  branch_eval_i;
    logic [2:0]            cond_i;
    logic                  flag_zero_o;
    logic                  flag_carry_o;
    logic                  flag_negative_o;
    logic                  branch_taken_o;
    logic                  stack_full_o;
    logic                  stack_empty_o;
    logic                  stack_err_o;

    modport master (
        output alu_result_i, alu_carry_i, load_flags_i, load_zn_i, set_carry_i, clr_carry_i,
               push_i, pop_i, branch_eval_i, cond_i,
        input  flag_zero_o, flag_carry_o, flag_negative_o, branch_taken_o,
               stack_full_o, stack_empty_o, stack_err_o
    );

    modport slave (
        input  alu_result_i, alu_carry_i, load_flags_i, load_zn_i, set_carry_i, clr_carry_i,
               push_i, pop_i, branch_eval_i, cond_i,
        output flag_zero_o, flag_carry_o, flag_negative_o, branch_taken_o,
               stack_full_o, stack_empty_o, stack_err_o
    );
endinterface

// File: rtl/flags_status_unit_lifo.sv
// rtl/flags_status_unit_lifo.sv - saved-flag LIFO with sticky overflow/underflow/collision error
module flags_lifo
    import flags_status_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  flags_t wdata,
    output flags_t rdata,
    output logic   full,
    output logic   empty,
    output logic   err
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] r_ptr;
    logic          r_err;
    flags_t        r_mem [STACK_DEPTH];

    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_bad;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    assign full      = (r_ptr == PW'(STACK_DEPTH));
    assign empty     = (r_ptr == '0);
    assign err       = r_err;
    assign w_push_ok = push & ~pop & ~full;
    assign w_pop_ok  = pop & ~push & ~empty;
    assign w_bad     = (push & pop) | (push & full) | (pop & empty);
    assign w_wr_idx  = r_ptr[AW-1:0];
    // Wraps harmlessly when empty; the entry is only consumed on a legal pop.
    assign w_top_idx = r_ptr[AW-1:0] - AW'(1);
    assign rdata     = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_ptr <= r_ptr + PW'(1);
            end else if (w_pop_ok) begin
                r_ptr <= r_ptr - PW'(1);
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/flags_status_unit.sv
// rtl/flags_status_unit.sv - Z/C/N flag registers, branch evaluation and push/pop of saved flags
module flags_status_unit
    import flags_status_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    flags_status_unit_if.slave  bus
);
    flags_t r_flags;
    logic   r_branch_taken;

    flags_t w_alu_flags;
    flags_t w_flags_next;
    flags_t w_pop_data;
    logic   w_full;
    logic   w_empty;
    logic   w_err;
    logic   w_pop_ok;

    assign w_alu_flags[FLAG_Z] = (bus.alu_result_i == '0);
    assign w_alu_flags[FLAG_C] = bus.alu_carry_i;
    assign w_alu_flags[FLAG_N] = bus.alu_result_i[DATA_WIDTH-1];
    assign w_pop_ok            = bus.pop_i & ~bus.push_i & ~w_empty;

    // Applied lowest priority first so each higher source overwrites only the bits it owns.
    always_comb begin
        w_flags_next = r_flags;
        if (bus.load_zn_i) begin
            w_flags_next[FLAG_Z] = w_alu_flags[FLAG_Z];
            w_flags_next[FLAG_N] = w_alu_flags[FLAG_N];
        end
        if (bus.load_flags_i) begin
            w_flags_next = w_alu_flags;
        end
        if (bus.set_carry_i && bus.clr_carry_i) begin
            w_flags_next[FLAG_C] = r_flags[FLAG_C];
        end else if (bus.set_carry_i || bus.clr_carry_i) begin
            w_flags_next[FLAG_C] = bus.set_carry_i;
        end
        if (w_pop_ok) begin
            w_flags_next = w_pop_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags        <= '0;
            r_branch_taken <= 1'b0;
        end else begin
            r_flags        <= w_flags_next;
            r_branch_taken <= bus.branch_eval_i & cond_met(branch_cond_t'(bus.cond_i), r_flags);
        end
    end

    flags_lifo #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.push_i),
        .pop   (bus.pop_i),
        .wdata (r_flags),
        .rdata (w_pop_data),
        .full  (w_full),
        .empty (w_empty),
        .err   (w_err)
    );

    assign bus.flag_zero_o     = r_flags[FLAG_Z];
    assign bus.flag_carry_o    = r_flags[FLAG_C];
    assign bus.flag_negative_o = r_flags[FLAG_N];
    assign bus.branch_taken_o  = r_branch_taken;
    assign bus.stack_full_o    = w_full;
    assign bus.stack_empty_o   = w_empty;
    assign bus.stack_err_o     = w_err;

endmodule

// File: tb/tb_flags_status_unit.sv
// tb/tb_flags_status_unit.sv - scoreboard bench for flags_status_unit
module tb_flags_status_unit;
    import flags_status_unit_pkg::*;

    localparam logic [6:0] LF  = 7'b1000000;
    localparam logic [6:0] LZN = 7'b0100000;
    localparam logic [6:0] SEC = 7'b0010000;
    localparam logic [6:0] CLC = 7'b0001000;
    localparam logic [6:0] PSH = 7'b0000100;
    localparam logic [6:0] POP = 7'b0000010;
    localparam logic [6:0] BE  = 7'b0000001;
    localparam logic [6:0] NON = 7'b0000000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    flags_status_unit_if #(.DATA_WIDTH(8)) bus ();

    flags_status_unit #(
        .DATA_WIDTH  (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    event sb_ev;
    int   n_checks = 0;
    int   n_errors = 0;

    // Observed vector order: {Z, C, N, branch_taken, full, empty, err}
    function automatic logic [6:0] observed();
        return {bus.flag_zero_o, bus.flag_carry_o, bus.flag_negative_o, bus.branch_taken_o,
                bus.stack_full_o, bus.stack_empty_o, bus.stack_err_o};
    endfunction

    initial begin : monitor
        sb_t e;
        logic [6:0] got;
        forever begin
            @(sb_ev);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observed();
                n_checks++;
                if (got !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got {z,c,n,br,full,empty,err}=%b required %b", e.name, got, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input logic [6:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
        -> sb_ev;
    endtask

    task automatic drive_idle();
        {bus.load_flags_i, bus.load_zn_i, bus.set_carry_i, bus.clr_carry_i,
         bus.push_i, bus.pop_i, bus.branch_eval_i} = NON;
    endtask

    task automatic cyc(input string nm, input logic [7:0] res, input logic cy,
                       input logic [6:0] strb, input logic [2:0] cond, input logic [6:0] e);
        @(negedge clk);
        bus.alu_result_i = res;
        bus.alu_carry_i  = cy;
        bus.cond_i       = cond;
        {bus.load_flags_i, bus.load_zn_i, bus.set_carry_i, bus.clr_carry_i,
         bus.push_i, bus.pop_i, bus.branch_eval_i} = strb;
        @(posedge clk);
        #1;
        expect_now(nm, e);
        drive_idle();
    endtask

    // Reset is checked before the next rising edge to prove it acts asynchronously.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 expect_now(nm, 7'b0000010);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.alu_result_i = 8'h00;
        bus.alu_carry_i  = 1'b0;
        bus.cond_i       = 3'd0;
        drive_idle();
        #2 expect_now("rst0", 7'b0000010);
        #20 reset = 1'b1;

        cyc("pop_empty", 8'h00, 1'b0, POP,      3'd0, 7'b0000011);
        cyc("ld_fe",     8'hFE, 1'b1, LF,       3'd0, 7'b0110011);
        cyc("push1",     8'h00, 1'b0, PSH,      3'd0, 7'b0110001);
        async_reset("rst_mid");

        cyc("sub55",     8'h00, 1'b1, LF,       3'd0, 7'b1100010);
        cyc("sub35",     8'hFE, 1'b0, LF,       3'd0, 7'b0010010);
        cyc("lzn00",     8'h00, 1'b1, LZN,      3'd0, 7'b1000010);
        cyc("br_race",   8'h07, 1'b0, LF | BE,  3'd2, 7'b0000010);
        cyc("br_nz",     8'h00, 1'b0, BE,       3'd2, 7'b0001010);
        cyc("br_drop",   8'h00, 1'b0, NON,      3'd2, 7'b0000010);
        cyc("clc_ld",    8'h80, 1'b1, LF | CLC, 3'd0, 7'b0010010);
        cyc("sec",       8'h00, 1'b0, SEC,      3'd0, 7'b0110010);

        cyc("push_a",    8'h00, 1'b0, PSH | LF, 3'd0, 7'b1000000);
        cyc("push_b",    8'h01, 1'b1, PSH | LF, 3'd0, 7'b0100000);
        cyc("push_c",    8'h80, 1'b0, PSH | LF, 3'd0, 7'b0010000);
        cyc("push_d",    8'h00, 1'b1, PSH | LF, 3'd0, 7'b1100100);
        cyc("push_full", 8'h00, 1'b0, PSH,      3'd0, 7'b1100101);
        cyc("pop_d",     8'h00, 1'b1, POP | LF, 3'd0, 7'b0010001);
        cyc("pop_c",     8'h00, 1'b0, POP,      3'd0, 7'b0100001);
        cyc("pop_b",     8'h00, 1'b0, POP,      3'd0, 7'b1000001);
        cyc("pop_a",     8'h00, 1'b0, POP,      3'd0, 7'b0110011);
        cyc("pop_extra", 8'h00, 1'b0, POP,      3'd0, 7'b0110011);

        async_reset("rst_again");
        cyc("ld_80",     8'h80, 1'b1, LF,        3'd0, 7'b0110010);
        cyc("push_one",  8'h00, 1'b0, PSH,       3'd0, 7'b0110000);
        cyc("ld_00",     8'h00, 1'b0, LF,        3'd0, 7'b1000000);
        cyc("collide",   8'h00, 1'b0, PSH | POP, 3'd0, 7'b1000001);
        cyc("pop_after", 8'h00, 1'b0, POP,       3'd0, 7'b0110011);
        cyc("br_c",      8'h00, 1'b0, BE,        3'd3, 7'b0111011);
        cyc("br_never",  8'h00, 1'b0, BE,        3'd7, 7'b0110011);
        cyc("br_n",      8'h00, 1'b0, BE,        3'd5, 7'b0111011);
        cyc("br_nz2",    8'h00, 1'b0, BE,        3'd2, 7'b0111011);
        cyc("idle",      8'h00, 1'b0, NON,       3'd0, 7'b0110011);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
